emissor_instrucao: RTL and testbench

Instruction issuer that drives the 3-bit `OpCode` bus consumed by the control decoder, the initiating side of the opcode interface. It holds a small program memory that is loaded through a write port. On `Start` it fetches words in order and presents each one with a valid/ready handshake. It inserts wait cycles after memory operations and stops on the stop opcode or at the end of the program.

---
 rtl/emissor_instrucao_pkg.sv | 27 ++
 rtl/emissor_instrucao_if.sv | 26 ++
 rtl/emissor_instrucao_memoria_programa.sv | 39 +++
 rtl/emissor_instrucao.sv | 162 ++++++++++++++++
 tb/tb_emissor_instrucao.sv | 261 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/emissor_instrucao_pkg.sv
// Shared control definitions: opcode encodings, issuer FSM states and the
// memory-opcode classifier used by the instruction issuer.
package pkg_controle;

    localparam logic [2:0] OP_SOMA = 3'b000;
    localparam logic [2:0] OP_SUB  = 3'b001;
    localparam logic [2:0] OP_DIV  = 3'b010;
    localparam logic [2:0] OP_MUL  = 3'b011;
    localparam logic [2:0] OP_CLR  = 3'b100;
    localparam logic [2:0] OP_STOP = 3'b101;
    localparam logic [2:0] OP_RD   = 3'b110;
    localparam logic [2:0] OP_WR   = 3'b111;

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StIssue,
        StWait,
        StHalt
    } estado_e;

    // Memory class is every opcode with the MSB set except the stop opcode.
    function automatic logic is_mem_op(input logic [2:0] op);
        return op[2] && (op != OP_STOP);
    endfunction

endpackage

// File: rtl/emissor_instrucao_if.sv
// Opcode bus between the instruction issuer (master) and the control
// decoder (slave): valid/ready handshake plus opcode and operand fields.
interface emissor_instrucao_if #(
    parameter int unsigned INSTR_W = 16
);

    logic               Valid;
    logic               Ready;
    logic [2:0]         OpCode;
    logic [INSTR_W-4:0] Operandos;

    modport master (
        output Valid,
        output OpCode,
        output Operandos,
        input  Ready
    );

    modport slave (
        input  Valid,
        input  OpCode,
        input  Operandos,
        output Ready
    );

endinterface

// File: rtl/emissor_instrucao_memoria_programa.sv
// Program memory: Depth x Width, one synchronous write port and one
// synchronous read port. The array is never reset; only the read register is.
module memoria_programa #(
    parameter int unsigned Depth = 16,
    parameter int unsigned Width = 16,
    localparam int unsigned Aw = $clog2(Depth)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             we_i,
    input  logic [Aw-1:0]    waddr_i,
    input  logic [Width-1:0] wdata_i,
    input  logic             re_i,
    input  logic [Aw-1:0]    raddr_i,
    output logic [Width-1:0] rdata_o
);

    logic [Width-1:0] mem_q [Depth];
    logic [Width-1:0] rdata_q;

    // Write port; contents survive reset.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Read port; register cleared on reset so the operand bus starts at zero.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/emissor_instrucao.sv
// Instruction issuer: fetches program words in order after Start and
// presents them on the opcode bus with a valid/ready handshake, inserting
// wait cycles after memory opcodes and halting on stop or at the top address.
// Optional feature macro: EMISSOR_STEP_EN (adds the Step single-step input).
module emissor_instrucao
    import pkg_controle::*;
#(
    parameter int unsigned PROG_DEPTH = 16,
    parameter int unsigned INSTR_W    = 16,
    parameter int unsigned MEM_WAIT   = 2,
    localparam int unsigned AW = $clog2(PROG_DEPTH)
) (
    input  logic                 Clock,
    input  logic                 Reset_n,
`ifdef EMISSOR_STEP_EN
    input  logic                 Step,
`endif
    input  logic                 ProgWe,
    input  logic [AW-1:0]        ProgAddr,
    input  logic [INSTR_W-1:0]   ProgData,
    input  logic                 Start,
    emissor_instrucao_if.master  bus,
    output logic [AW-1:0]        PC,
    output logic                 Busy,
    output logic                 Halted
);

    localparam int unsigned CW = (MEM_WAIT > 1) ? $clog2(MEM_WAIT) : 1;
    localparam logic [AW-1:0] PcTop = AW'(PROG_DEPTH - 1);

    estado_e            st_q, st_d;
    logic [AW-1:0]      pc_q, pc_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [INSTR_W-1:0] rd_data;
    logic [2:0]         op;
    logic               prog_we;
    logic               accept;
`ifdef EMISSOR_STEP_EN
    logic               armed_q, armed_d;
`endif

    // Program writes are only allowed while nothing is being fetched.
    assign prog_we = ProgWe && ((st_q == StIdle) || (st_q == StHalt));
    assign op      = rd_data[INSTR_W-1 -: 3];
    assign accept  = (st_q == StIssue) && bus.Ready;

    memoria_programa #(
        .Depth (PROG_DEPTH),
        .Width (INSTR_W)
    ) u_mem (
        .clk_i   (Clock),
        .rst_ni  (Reset_n),
        .we_i    (prog_we),
        .waddr_i (ProgAddr),
        .wdata_i (ProgData),
        .re_i    (st_q == StFetch),
        .raddr_i (pc_q),
        .rdata_o (rd_data)
    );

    // State, PC and wait-counter registers.
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            st_q  <= StIdle;
            pc_q  <= '0;
            cnt_q <= '0;
        end else begin
            st_q  <= st_d;
            pc_q  <= pc_d;
            cnt_q <= cnt_d;
        end
    end

`ifdef EMISSOR_STEP_EN
    // Start arms execution; the following Step launches the fetch.
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            armed_q <= 1'b0;
        end else begin
            armed_q <= armed_d;
        end
    end
`endif

    // Next-state logic for the issue sequence.
    always_comb begin
        st_d  = st_q;
        pc_d  = pc_q;
        cnt_d = cnt_q;
`ifdef EMISSOR_STEP_EN
        armed_d = armed_q;
`endif
        unique case (st_q)
            StIdle, StHalt: begin
`ifdef EMISSOR_STEP_EN
                if (Start) begin
                    pc_d    = '0;
                    armed_d = 1'b1;
                end
                if (armed_q && Step) begin
                    st_d    = StFetch;
                    armed_d = 1'b0;
                end
`else
                if (Start) begin
                    st_d = StFetch;
                    pc_d = '0;
                end
`endif
            end
            StFetch: begin
                st_d = StIssue;
            end
            StIssue: begin
                if (accept) begin
                    if ((op == OP_STOP) || (pc_q == PcTop)) begin
                        st_d = StHalt;
                    end else if (is_mem_op(op)) begin
                        // Counter holds remaining WAIT cycles minus one.
                        st_d  = StWait;
                        cnt_d = CW'(MEM_WAIT - 1);
                    end else begin
`ifdef EMISSOR_STEP_EN
                        // Park in WAIT with no delay so the next fetch waits for Step.
                        st_d  = StWait;
                        cnt_d = '0;
`else
                        st_d = StFetch;
                        pc_d = pc_q + AW'(1);
`endif
                    end
                end
            end
            StWait: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CW'(1);
`ifdef EMISSOR_STEP_EN
                end else if (Step) begin
`else
                end else begin
`endif
                    st_d = StFetch;
                    pc_d = pc_q + AW'(1);
                end
            end
            default: begin
                st_d = StIdle;
            end
        endcase
    end

    // Outputs; an idle bus shows the stop opcode to keep the decoder quiet.
    always_comb begin
        bus.Valid     = (st_q == StIssue);
        bus.OpCode    = (st_q == StIssue) ? op : OP_STOP;
        bus.Operandos = rd_data[INSTR_W-4:0];
        PC            = pc_q;
        Busy          = (st_q == StFetch) || (st_q == StIssue) || (st_q == StWait);
        Halted        = (st_q == StHalt);
    end

endmodule

// File: tb/tb_emissor_instrucao.sv
// Bench for emissor_instrucao: directed programs, a program-level model of
// the issued word sequence and acceptance spacing, and literal spot checks.
module tb_emissor_instrucao;

    localparam int unsigned DEPTH = 16;
    localparam int unsigned IW    = 16;
    localparam int unsigned MW    = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ProgWe = 1'b0;
    logic [3:0]  ProgAddr = '0;
    logic [15:0] ProgData = '0;
    logic        Start = 1'b0;
    logic [3:0]  PC;
    logic        Busy;
    logic        Halted;

    emissor_instrucao_if #(.INSTR_W(IW)) bus ();

    emissor_instrucao #(
        .PROG_DEPTH (DEPTH),
        .INSTR_W    (IW),
        .MEM_WAIT   (MW)
    ) dut (
        .Clock    (clk),
        .Reset_n  (rst_n),
        .ProgWe   (ProgWe),
        .ProgAddr (ProgAddr),
        .ProgData (ProgData),
        .Start    (Start),
        .bus      (bus),
        .PC       (PC),
        .Busy     (Busy),
        .Halted   (Halted)
    );

    always #5 clk = ~clk;

    int          n_vec = 0;
    int          n_err = 0;
    int          cyc = 0;
    logic [15:0] mdl_mem [DEPTH];
    logic [15:0] exp_q [$];
    int          exp_n;
    int          exp_pc;
    int          exp_gap;
    int          n_acc = 0;
    int          last_acc = 0;
    logic [15:0] acc_word [32];
    int          acc_time [32];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic bit model_mem_op(input logic [2:0] op);
        return (op == 3'b100) || (op == 3'b110) || (op == 3'b111);
    endfunction

    // Program-order walk: issue words from 0 until stop opcode or top address.
    task automatic build_expected();
        int pc;
        exp_q.delete();
        pc = 0;
        forever begin
            exp_q.push_back(mdl_mem[pc]);
            if (mdl_mem[pc][15:13] == 3'b101 || pc == DEPTH - 1) break;
            pc++;
        end
        exp_pc = pc;
        exp_n  = exp_q.size();
    endtask

    // Per-cycle bus check against the model queue and acceptance spacing.
    always @(negedge clk) begin
        logic [15:0] w;
        if (rst_n) begin
            if (bus.Valid) begin
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL issue_unexpected: got word %0h, required none", {bus.OpCode, bus.Operandos});
                end else begin
                    chk("issue_opcode", 32'(bus.OpCode), 32'(exp_q[0][15:13]));
                    chk("issue_operand", 32'(bus.Operandos), 32'(exp_q[0][12:0]));
                end
                if (bus.Ready) begin
                    if (n_acc > 0) chk("accept_gap", 32'(cyc - last_acc), 32'(exp_gap));
                    if (exp_q.size() != 0) begin
                        w = exp_q.pop_front();
                        exp_gap = 2 + (model_mem_op(w[15:13]) ? MW : 0);
                    end
                    if (n_acc < 32) begin
                        acc_word[n_acc] = {bus.OpCode, bus.Operandos};
                        acc_time[n_acc] = cyc;
                    end
                    last_acc = cyc;
                    n_acc++;
                end
            end else begin
                chk("idle_opcode_stop", 32'(bus.OpCode), 32'd5);
            end
        end
    end

    task automatic write_word(input logic [3:0] a, input logic [15:0] d);
        @(posedge clk); #1;
        ProgWe = 1'b1; ProgAddr = a; ProgData = d;
        mdl_mem[a] = d;
        @(posedge clk); #1;
        ProgWe = 1'b0;
    endtask

    // Pulse Start (optionally with a same-cycle write) and pin fetch latency.
    task automatic start_run(input bit wr, input logic [3:0] a, input logic [15:0] d);
        @(posedge clk); #1;
        if (wr) begin
            ProgWe = 1'b1; ProgAddr = a; ProgData = d;
            mdl_mem[a] = d;
        end
        build_expected();
        n_acc = 0;
        Start = 1'b1;
        @(posedge clk); #1;
        Start = 1'b0;
        ProgWe = 1'b0;
        @(negedge clk);
        chk("fetch_valid_low", 32'(bus.Valid), 32'd0);
        chk("fetch_busy", 32'(Busy), 32'd1);
        @(negedge clk);
        chk("issue_valid_high", 32'(bus.Valid), 32'd1);
    endtask

    task automatic wait_halt();
        int i = 0;
        while (!Halted && i < 300) begin
            @(negedge clk);
            i++;
        end
        chk("halt_reached", 32'(Halted), 32'd1);
        chk("halt_latency", 32'(cyc - last_acc), 32'd1);
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        chk("accept_count", 32'(n_acc), 32'(exp_n));
        chk("pc_final", 32'(PC), 32'(exp_pc));
        chk("busy_in_halt", 32'(Busy), 32'd0);
    endtask

    initial begin
        bus.Ready = 1'b1;
        #3;
        chk("rst_valid", 32'(bus.Valid), 32'd0);
        chk("rst_opcode", 32'(bus.OpCode), 32'd5);
        chk("rst_operandos", 32'(bus.Operandos), 32'd0);
        chk("rst_pc", 32'(PC), 32'd0);
        chk("rst_busy", 32'(Busy), 32'd0);
        chk("rst_halted", 32'(Halted), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int i = 0; i < DEPTH; i++) write_word(4'(i), 16'hA000);

        // Two ALU words then stop.
        write_word(4'd0, 16'h0123);
        write_word(4'd1, 16'h2456);
        write_word(4'd2, 16'hA000);
        start_run(1'b0, 4'd0, 16'h0);
        wait_halt();
        chk("t1_acc", 32'(n_acc), 32'd3);
        chk("t1_op0", 32'(acc_word[0][15:13]), 32'd0);
        chk("t1_op1", 32'(acc_word[1][15:13]), 32'd1);
        chk("t1_op2", 32'(acc_word[2][15:13]), 32'd5);
        chk("t1_pc", 32'(PC), 32'd2);
        chk("t1_halted", 32'(Halted), 32'd1);

        // Back-pressure during ISSUE of 011.
        write_word(4'd0, 16'h6ABC);
        write_word(4'd1, 16'hA000);
        bus.Ready = 1'b0;
        start_run(1'b0, 4'd0, 16'h0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("t2_hold_valid", 32'(bus.Valid), 32'd1);
            chk("t2_hold_opcode", 32'(bus.OpCode), 32'd3);
            chk("t2_hold_noacc", 32'(n_acc), 32'd0);
        end
        @(posedge clk); #1;
        bus.Ready = 1'b1;
        wait_halt();
        chk("t2_acc", 32'(n_acc), 32'd2);
        chk("t2_word0", 32'(acc_word[0]), 32'h6ABC);

        // Memory read followed by ALU: gap is 2+MEM_WAIT.
        write_word(4'd0, 16'hC011);
        write_word(4'd1, 16'h0022);
        write_word(4'd2, 16'hA000);
        start_run(1'b0, 4'd0, 16'h0);
        wait_halt();
        chk("t3_gap_mem", 32'(acc_time[1] - acc_time[0]), 32'd4);
        chk("t3_gap_alu", 32'(acc_time[2] - acc_time[1]), 32'd2);

        // Full program of ALU words, no stop: halts at top without wrapping.
        for (int i = 0; i < DEPTH; i++) write_word(4'(i), 16'(i));
        start_run(1'b0, 4'd0, 16'h0);
        wait_halt();
        chk("t4_acc", 32'(n_acc), 32'd16);
        chk("t4_pc", 32'(PC), 32'd15);
        repeat (3) @(negedge clk);
        chk("t4_pc_hold", 32'(PC), 32'd15);
        chk("t4_valid_low", 32'(bus.Valid), 32'd0);

        // Write (and Start) during WAIT are ignored.
        write_word(4'd0, 16'hE001);
        write_word(4'd1, 16'h1234);
        write_word(4'd2, 16'hA000);
        start_run(1'b0, 4'd0, 16'h0);
        for (int i = 0; i < 50 && n_acc < 1; i++) @(negedge clk);
        chk("t5_first_acc", 32'(n_acc), 32'd1);
        @(posedge clk); #1;
        ProgWe = 1'b1; ProgAddr = 4'd1; ProgData = 16'h4BAD; Start = 1'b1;
        chk("t5_busy_wait", 32'(Busy), 32'd1);
        @(posedge clk); #1;
        ProgWe = 1'b0; Start = 1'b0;
        wait_halt();
        start_run(1'b0, 4'd0, 16'h0);
        wait_halt();
        chk("t5_word1_kept", 32'(acc_word[1]), 32'h1234);

        // Asynchronous reset during ISSUE; memory retained; write+Start same cycle.
        write_word(4'd0, 16'h2055);
        write_word(4'd1, 16'h4066);
        write_word(4'd2, 16'hA000);
        bus.Ready = 1'b0;
        start_run(1'b0, 4'd0, 16'h0);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("t6_rst_valid", 32'(bus.Valid), 32'd0);
        chk("t6_rst_opcode", 32'(bus.OpCode), 32'd5);
        chk("t6_rst_busy", 32'(Busy), 32'd0);
        chk("t6_rst_pc", 32'(PC), 32'd0);
        exp_q.delete();
        @(posedge clk);
        @(posedge clk); #1;
        rst_n = 1'b1;
        bus.Ready = 1'b1;
        start_run(1'b1, 4'd0, 16'h2777);
        wait_halt();
        chk("t6_new_word0", 32'(acc_word[0]), 32'h2777);
        chk("t6_kept_word1", 32'(acc_word[1]), 32'h4066);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
